demux_deser: RTL

- Registered 1-to-4 demultiplexer/deserializer; the inverse of the team's 4:1 bit-select mux.
- Accepts one data bit per handshake and steers it into one of four output bit positions. Position comes from an external select (manual mode) or an internal round-robin counter (auto mode).
- Presents the assembled 4-bit word with a valid/ready handshake once every position has been written.
- Sits between a serial/bit-select source and any 4-bit parallel consumer.

---
 rtl/demux_deser.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/demux_deser.sv
// Registered 1-to-4 demultiplexer/deserializer: steers one bit per accept into a 4-bit word.
// Optional macro DEMUX_DESER_PARITY_EN adds the registered out_parity output.
module demux_deser #(
    parameter int N_OUT = 4,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             auto_mode,
    output logic [N_OUT-1:0] d_out,
    output logic [N_OUT-1:0] fill_mask,
    output logic             out_valid,
`ifdef DEMUX_DESER_PARITY_EN
    output logic             out_parity,
`endif
    input  logic             out_ready
);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [N_OUT-1:0]   d_out_r;
    logic [N_OUT-1:0]   fill_mask_r;
    logic [SEL_W-1:0]   cnt_r;
    logic               mode_r;

    logic               accept_s;
    logic               release_s;
    logic               first_s;
    logic               mode_eff_s;
    logic [SEL_W-1:0]   pos_s;
    logic [N_OUT-1:0]   d_next_s;
    logic [N_OUT-1:0]   mask_next_s;
    logic               complete_s;

    assign accept_s    = in_valid && (state_r == FILL);
    assign release_s   = out_ready && (state_r == HOLD);
    assign first_s     = (fill_mask_r == {N_OUT{1'b0}});
    assign mask_next_s = fill_mask_r | ({{(N_OUT-1){1'b0}}, 1'b1} << pos_s);
    assign complete_s  = accept_s && (mask_next_s == {N_OUT{1'b1}});

    // Effective mode: the live auto_mode only on the first bit, the latched mode afterwards
    always_comb begin
        mode_eff_s = mode_r;
        pos_s      = in_sel;
        if (first_s) begin
            mode_eff_s = auto_mode;
        end else begin
            mode_eff_s = mode_r;
        end
        if (mode_eff_s) begin
            pos_s = cnt_r;
        end else begin
            pos_s = in_sel;
        end
    end

    // Candidate word with the incoming bit written at the selected position
    always_comb begin
        d_next_s        = d_out_r;
        d_next_s[pos_s] = in_bit;
    end

    // Next-state logic for the fill/hold handshake
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FILL: begin
                if (complete_s) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = FILL;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next_s = FILL;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: state_next_s = FILL;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= FILL;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Word, fill mask, round-robin counter and mode latch
    always_ff @(posedge clk) begin
        if (rst) begin
            d_out_r     <= {N_OUT{1'b0}};
            fill_mask_r <= {N_OUT{1'b0}};
            cnt_r       <= {SEL_W{1'b0}};
            mode_r      <= 1'b0;
        end else if (accept_s) begin
            d_out_r     <= d_next_s;
            fill_mask_r <= mask_next_s;
            if (first_s) begin
                mode_r <= auto_mode;
            end
            if (complete_s) begin
                cnt_r <= {SEL_W{1'b0}};
            end else if (mode_eff_s) begin
                cnt_r <= cnt_r + {{(SEL_W-1){1'b0}}, 1'b1};
            end
        end else if (release_s) begin
            fill_mask_r <= {N_OUT{1'b0}};
        end
    end

`ifdef DEMUX_DESER_PARITY_EN
    logic parity_r;

    function automatic logic parity4(input logic [N_OUT-1:0] word);
        return ^word;
    endfunction

    // Parity is captured with the completing bit and cleared when the word leaves
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_r <= 1'b0;
        end else if (complete_s) begin
            parity_r <= parity4(d_next_s);
        end else if (release_s) begin
            parity_r <= 1'b0;
        end
    end

    assign out_parity = parity_r;
`endif

    assign in_ready  = (state_r == FILL);
    assign out_valid = (state_r == HOLD);
    assign d_out     = d_out_r;
    assign fill_mask = fill_mask_r;

endmodule
